// File: rtl/count_mon_pkg.sv
// count_mon_pkg: shared encodings for count_monitor.
//   dir_e   : step classification, also the encoding driven on the dir port
//   state_e : monitor FSM states
package count_mon_pkg;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10,
    DIR_JMP  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_HOLD = 2'b01,
    S_UP   = 2'b10,
    S_DN   = 2'b11
  } state_e;

endpackage

// File: rtl/count_monitor_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event this edge
//   clr        : clear this edge (an event on the same edge still counts -> 1)
//   value      : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (clr)
      value <= inc ? ONE : '0;
    else if (inc && (value != '1))
      value <= value + ONE;
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: observes an up/down counter's Q each clock and classifies
// every step as hold / up / down / jump, counting wraps and illegal jumps.
//   clk         : same clock as the monitored counter
//   REST        : async active-low reset
//   Q           : monitored count
//   err_clr     : sync clear of err and jump_cnt (a same-edge jump wins)
//   dir         : last classification (00 hold, 01 up, 10 down, 11 jump)
//   turn        : one-cycle pulse on a direction reversal
//   wrap_up_cnt : saturating count of max->0 up-steps
//   wrap_dn_cnt : saturating count of 0->max down-steps
//   jump_cnt    : saturating count of illegal jumps
//   err         : sticky illegal-jump flag
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             REST,
  input  logic [WIDTH-1:0] Q,
  input  logic             err_clr,
  output logic [1:0]       dir,
  output logic             turn,
  output logic [CNT_W-1:0] wrap_up_cnt,
  output logic [CNT_W-1:0] wrap_dn_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] q_prev;
  logic [WIDTH-1:0] delta;
  dir_e             step;
  logic             last_dir;   // 0 = up, 1 = down
  logic             last_vld;
  logic             is_up, is_dn, is_jmp;
  logic             turn_nxt;
  logic             wrap_up_ev, wrap_dn_ev;

  // Step classifier + next state. Modular difference makes wraps look like
  // ordinary +1/-1 steps. INIT only primes q_prev, so nothing is classified.
  always_comb begin
    delta     = Q - q_prev;
    step      = DIR_HOLD;
    state_nxt = state;
    if (state == S_INIT) begin
      state_nxt = S_HOLD;
    end else begin
      if (delta == '0)            step = DIR_HOLD;
      else if (delta == ONE)      step = DIR_UP;
      else if (delta == ALL_ONES) step = DIR_DN;
      else                        step = DIR_JMP;
      case (step)
        DIR_UP:  state_nxt = S_UP;
        DIR_DN:  state_nxt = S_DN;
        default: state_nxt = S_HOLD;
      endcase
    end
  end

  assign is_up  = (step == DIR_UP);
  assign is_dn  = (step == DIR_DN);
  assign is_jmp = (step == DIR_JMP);

  // Reversal is measured against the last non-hold direction, so holds
  // in between do not hide a turn; a jump invalidates that history.
  assign turn_nxt   = (is_up || is_dn) && last_vld && (is_dn != last_dir);
  assign wrap_up_ev = is_up && (q_prev == ALL_ONES) && (Q == '0);
  assign wrap_dn_ev = is_dn && (q_prev == '0) && (Q == ALL_ONES);

  always_ff @(posedge clk or negedge REST) begin
    if (!REST) begin
      state    <= S_INIT;
      q_prev   <= '0;
      dir      <= DIR_HOLD;
      turn     <= 1'b0;
      last_dir <= 1'b0;
      last_vld <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_prev <= Q;
      dir    <= step;
      turn   <= turn_nxt;
      if (is_up || is_dn) begin
        last_dir <= is_dn;
        last_vld <= 1'b1;
      end else if (is_jmp) begin
        last_vld <= 1'b0;
      end
      if (is_jmp)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_wrap_up (
    .clk   (clk),
    .rst_n (REST),
    .inc   (wrap_up_ev),
    .clr   (1'b0),
    .value (wrap_up_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wrap_dn (
    .clk   (clk),
    .rst_n (REST),
    .inc   (wrap_dn_ev),
    .clr   (1'b0),
    .value (wrap_dn_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_jump (
    .clk   (clk),
    .rst_n (REST),
    .inc   (is_jmp),
    .clr   (err_clr),
    .value (jump_cnt)
  );

endmodule
